// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer: picks sequential advance or a forced PC each cycle and mirrors the fetch PC.
// Optional FETCH_PERF_CNT_EN adds saturating stall/halt-cycle and redirect counters.
module fetch_sequencer #(
   parameter int PC_W         = 8,
   parameter int PC_STEP      = 4,
   parameter int RESET_PC     = 0,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   input  logic            halt_req,
   input  logic            resume,
   output logic            pcWrEn,
   output logic [PC_W-1:0] newPc,
   output logic            fetch_valid,
   output logic            if_id_flush,
   output logic            misalign,
   output logic [PC_W-1:0] pc_mirror,
   output logic [2:0]      state
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]     stall_cnt,
   output logic [15:0]     redirect_cnt
`endif
);

   typedef enum logic [2:0] {
      S_BOOT  = 3'd0,
      S_RUN   = 3'd1,
      S_STALL = 3'd2,
      S_FLUSH = 3'd3,
      S_HALT  = 3'd4
   } state_e;

   localparam logic [PC_W-1:0] STEP     = PC_W'(PC_STEP);
   localparam logic [PC_W-1:0] LOW_MASK = PC_W'(PC_STEP - 1);
   localparam logic [PC_W-1:0] RST_PC   = PC_W'(RESET_PC);
   localparam logic [3:0]      CNT_INIT = 4'(FLUSH_CYCLES - 1);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [3:0]      cnt_q, cnt_d;

   always_comb begin
      pcWrEn      = 1'b1;
      newPc       = pc_q;
      fetch_valid = 1'b0;
      if_id_flush = 1'b0;
      misalign    = 1'b0;
      state_d     = state_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_BOOT: state_d = S_RUN;
         S_RUN, S_STALL: begin
            if (branch_taken) begin
               newPc       = branch_target & ~LOW_MASK;
               if_id_flush = 1'b1;
               misalign    = |(branch_target & LOW_MASK);
               if (FLUSH_CYCLES == 1) begin
                  state_d = S_RUN;
               end else begin
                  state_d = S_FLUSH;
                  cnt_d   = CNT_INIT;
               end
            end else if (halt_req) begin
               state_d = S_HALT;
            end else if (stall) begin
               state_d = S_STALL;
            end else begin
               pcWrEn      = 1'b0;
               fetch_valid = 1'b1;
               state_d     = S_RUN;
            end
         end
         // Requests are deliberately dropped while bubbles drain; a level halt_req is seen on return to RUN.
         S_FLUSH: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = S_RUN;
         end
         S_HALT: if (resume) state_d = S_RUN;
         default: state_d = S_BOOT;
      endcase
      pc_d = pcWrEn ? newPc : pc_q + STEP;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_BOOT;
         pc_q    <= RST_PC;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc_mirror = pc_q;
   assign state     = state_q;

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] stall_cnt_q, redirect_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q    <= 16'd0;
         redirect_cnt_q <= 16'd0;
      end else begin
         if ((state_q == S_STALL || state_q == S_HALT) && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
         if (if_id_flush && redirect_cnt_q != 16'hFFFF)
            redirect_cnt_q <= redirect_cnt_q + 16'd1;
      end
   end

   assign stall_cnt    = stall_cnt_q;
   assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed table-driven bench for fetch_sequencer (default parameters) plus async-reset corner sequences.
module tb_fetch_sequencer;

   logic       clk, reset, stall, branch_taken, halt_req, resume;
   logic [7:0] branch_target;
   logic       pcWrEn, fetch_valid, if_id_flush, misalign;
   logic [7:0] newPc, pc_mirror;
   logic [2:0] state;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] stall_cnt, redirect_cnt;
`endif

   fetch_sequencer dut (
      .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .halt_req(halt_req), .resume(resume),
      .pcWrEn(pcWrEn), .newPc(newPc), .fetch_valid(fetch_valid),
      .if_id_flush(if_id_flush), .misalign(misalign), .pc_mirror(pc_mirror),
      .state(state)
`ifdef FETCH_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // exp packs {pcWrEn, newPc, fetch_valid, if_id_flush, misalign, pc_mirror, state}
   typedef struct {
      logic        rn, st, br;
      logic [7:0]  tgt;
      logic        hl, rs;
      logic [22:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input logic rn, st, br, input logic [7:0] tgt,
                               input logic hl, rs, we, input logic [7:0] npc,
                               input logic fv, fl, mis, input logic [7:0] pc,
                               input logic [2:0] s);
      vec_t v;
      v.rn = rn; v.st = st; v.br = br; v.tgt = tgt; v.hl = hl; v.rs = rs;
      v.exp = {we, npc, fv, fl, mis, pc, s};
      return v;
   endfunction

   function automatic logic [22:0] act();
      return {pcWrEn, newPc, fetch_valid, if_id_flush, misalign, pc_mirror, state};
   endfunction

   task automatic chk(input string name, input logic [22:0] got, input logic [22:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got we=%b npc=%h fv=%b fl=%b mis=%b pc=%h st=%0d, expected we=%b npc=%h fv=%b fl=%b mis=%b pc=%h st=%0d",
                  name, got[22], got[21:14], got[13], got[12], got[11], got[10:3], got[2:0],
                  exp[22], exp[21:14], exp[13], exp[12], exp[11], exp[10:3], exp[2:0]);
      end
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
      halt_req = 1'b0; resume = 1'b0;

      //                rn st br tgt    hl rs   we npc    fv fl ms pc     st
      // boot
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0,   1, 8'h00, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0,   1, 8'h00, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0,   1, 8'h00, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0,   1, 8'h00, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0,   0, 8'h00, 1, 0, 0, 8'h00, 1));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0,   0, 8'h04, 1, 0, 0, 8'h04, 1));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0,   0, 8'h08, 1, 0, 0, 8'h08, 1));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0,   0, 8'h0C, 1, 0, 0, 8'h0C, 1));
      // stall 3 cycles at 0x10
      tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0,   1, 8'h10, 0, 0, 0, 8'h10, 1));
      tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0,   1, 8'h10, 0, 0, 0, 8'h10, 2));
      tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0,   1, 8'h10, 0, 0, 0, 8'h10, 2));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0,   0, 8'h10, 1, 0, 0, 8'h10, 2));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0,   0, 8'h14, 1, 0, 0, 8'h14, 1));
      // redirect to 0x40, requests ignored during the bubble
      tbl.push_back(mk(1, 0, 1, 8'h40, 0, 0,   1, 8'h40, 0, 1, 0, 8'h18, 1));
      tbl.push_back(mk(1, 1, 1, 8'h80, 0, 0,   1, 8'h40, 0, 0, 0, 8'h40, 3));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0,   0, 8'h40, 1, 0, 0, 8'h40, 1));
      // redirect beats halt+stall, misaligned target; halt pending through flush
      tbl.push_back(mk(1, 1, 1, 8'h22, 1, 0,   1, 8'h20, 0, 1, 1, 8'h44, 1));
      tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0,   1, 8'h20, 0, 0, 0, 8'h20, 3));
      tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0,   1, 8'h20, 0, 0, 0, 8'h20, 1));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1,   1, 8'h20, 0, 0, 0, 8'h20, 4));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0,   0, 8'h20, 1, 0, 0, 8'h20, 1));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0,   0, 8'h24, 1, 0, 0, 8'h24, 1));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0,   0, 8'h28, 1, 0, 0, 8'h28, 1));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0,   0, 8'h2C, 1, 0, 0, 8'h2C, 1));
      // halt at 0x30, branch/stall ignored, resume, resume in RUN is a no-op
      tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0,   1, 8'h30, 0, 0, 0, 8'h30, 1));
      tbl.push_back(mk(1, 1, 1, 8'h80, 0, 0,   1, 8'h30, 0, 0, 0, 8'h30, 4));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1,   1, 8'h30, 0, 0, 0, 8'h30, 4));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0,   0, 8'h30, 1, 0, 0, 8'h30, 1));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1,   0, 8'h34, 1, 0, 0, 8'h34, 1));
      // wrap-around from 0xF8
      tbl.push_back(mk(1, 0, 1, 8'hF8, 0, 0,   1, 8'hF8, 0, 1, 0, 8'h38, 1));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0,   1, 8'hF8, 0, 0, 0, 8'hF8, 3));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0,   0, 8'hF8, 1, 0, 0, 8'hF8, 1));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0,   0, 8'hFC, 1, 0, 0, 8'hFC, 1));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0,   0, 8'h00, 1, 0, 0, 8'h00, 1));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0,   0, 8'h04, 1, 0, 0, 8'h04, 1));
      // redirect from STALL with misaligned target, then sit in FLUSH
      tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0,   1, 8'h08, 0, 0, 0, 8'h08, 1));
      tbl.push_back(mk(1, 0, 1, 8'h53, 0, 0,   1, 8'h50, 0, 1, 1, 8'h08, 2));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0,   1, 8'h50, 0, 0, 0, 8'h50, 3));

      foreach (tbl[i]) begin
         @(negedge clk);
         reset = tbl[i].rn; stall = tbl[i].st; branch_taken = tbl[i].br;
         branch_target = tbl[i].tgt; halt_req = tbl[i].hl; resume = tbl[i].rs;
         #1;
         chk($sformatf("vec%0d", i), act(), tbl[i].exp);
      end

      // async reset in the middle of a FLUSH cycle, before the next edge
      #2 reset = 1'b0;
      #1 chk("midflush_reset", act(), {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0});
      @(negedge clk);
      reset = 1'b1;
      #1 chk("reboot_boot", act(), {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0});
      @(negedge clk);
      #1 chk("reboot_run", act(), {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd1});

`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (stall_cnt !== 16'd0 || redirect_cnt !== 16'd0) begin
         errors++;
         $display("FAIL perf_reset: got stall=%0d redir=%0d, expected 0 0", stall_cnt, redirect_cnt);
      end
      @(negedge clk); stall = 1'b1;
      @(negedge clk);
      @(negedge clk); stall = 1'b0; branch_taken = 1'b1; branch_target = 8'h60;
      @(negedge clk); branch_taken = 1'b0;
      #1;
      checks++;
      if (stall_cnt !== 16'd2 || redirect_cnt !== 16'd1) begin
         errors++;
         $display("FAIL perf_count: got stall=%0d redir=%0d, expected 2 1", stall_cnt, redirect_cnt);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
